uart_frame_loader: RTL and testbench

- Byte-stream consumer sitting directly downstream of the UART receiver.
- Takes its per-byte strobe (rx_done) and byte (rx_data), finds a 2-byte frame header and writes the following IMG_W*IMG_H pixel bytes into the image buffer through a simple write port.
- Signals frame completion or error to the inference controller.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_byte_strobe.sv | 35 +++
 rtl/uart_frame_loader.sv | 206 ++++++++++++++++++++
 tb/tb_uart_frame_loader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART frame loader: FSM state
//                encoding, frame header bytes and default image geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    S_HDR0  = 2'd0,
    S_HDR1  = 2'd1,
    S_PIX   = 2'd2,
    S_CKSUM = 2'd3
  } state_e;

  localparam logic [7:0] HDR0_BYTE = 8'hAA;
  localparam logic [7:0] HDR1_BYTE = 8'h55;

  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int IMG_PIX   = DEF_IMG_W * DEF_IMG_H;

  function automatic int img_pix(input int w, input int h);
    return w * h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_strobe.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_strobe
//  Description : Turns the UART receiver's rx_done level (one or more cycles
//                high per byte) into a single-cycle byte_vld on its rising
//                edge, with the byte sampled in that same cycle.
//  Ports       : clk, rst_n   - clock, asynchronous active-low reset
//                rx_done      - byte strobe from the receiver
//                rx_data      - received byte
//                byte_vld     - one cycle per received byte
//                rx_byte      - byte qualified by byte_vld
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_strobe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       byte_vld,
  output logic [7:0] rx_byte
);

  logic rx_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_done_q <= 1'b0;
    else        rx_done_q <= rx_done;
  end

  // Edge detect against the delayed copy: a long-held rx_done yields one byte.
  assign byte_vld = rx_done & ~rx_done_q;
  assign rx_byte  = rx_data;

endmodule
`default_nettype wire

// File: rtl/uart_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_loader
//  Description : Finds a two-byte header (HDR0, HDR1) in the UART byte stream
//                and writes the following IMG_W*IMG_H pixel bytes row-major
//                into the image buffer. Reports frame completion, abort
//                (inter-byte timeout / checksum) and frames refused because
//                the buffer is busy.
//  Options     : UART_CKSUM_EN - when defined, one trailing checksum byte
//                (8-bit sum of the pixels) is expected after the pixels.
//  Ports       : clk, rst_n   - clock, asynchronous active-low reset
//                rx_done      - byte strobe from the UART receiver
//                rx_data      - received byte
//                img_busy     - inference is reading the buffer
//                wr_en/wr_addr/wr_data - pixel buffer write port
//                frame_done   - pulse, frame completely written
//                frame_err    - pulse, frame aborted
//                frame_drop   - pulse, header refused while busy
//                loading      - frame load in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_loader
  import uart_pkg::*;
#(
  parameter int          IMG_W       = DEF_IMG_W,
  parameter int          IMG_H       = DEF_IMG_H,
  parameter int          ADDR_W      = 10,
  parameter logic [7:0]  HDR0        = HDR0_BYTE,
  parameter logic [7:0]  HDR1        = HDR1_BYTE,
  parameter logic [23:0] TIMEOUT_CLK = 24'd5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              img_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              frame_drop,
  output logic              loading
);

  localparam int                N_PIX    = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_PIX - 1);

  logic       byte_vld;
  logic [7:0] rx_byte;

  uart_byte_strobe u_strobe (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .byte_vld (byte_vld),
    .rx_byte  (rx_byte)
  );

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [23:0]       tout_q, tout_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;
  logic              loading_q, loading_d;
`ifdef UART_CKSUM_EN
  logic [7:0]        cksum_q, cksum_d;
`endif

  // Timeout fires on the clock that would bring the counter to TIMEOUT_CLK.
  // An accepted byte in that same cycle takes priority (see FSM ordering).
  logic tout_hit;
  assign tout_hit = (tout_q == TIMEOUT_CLK - 24'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    drop_d    = 1'b0;
    loading_d = loading_q;
`ifdef UART_CKSUM_EN
    cksum_d   = cksum_q;
`endif
    tout_d    = (state_q == S_HDR0 || byte_vld || tout_hit) ? 24'd0 : tout_q + 24'd1;

    case (state_q)
      S_HDR0: begin
        if (byte_vld && rx_byte == HDR0) state_d = S_HDR1;
      end
      S_HDR1: begin
        if (byte_vld) begin
          if (rx_byte == HDR1) begin
            if (img_busy) begin
              drop_d  = 1'b1;
              state_d = S_HDR0;
            end else begin
              state_d   = S_PIX;
              cnt_d     = '0;
              loading_d = 1'b1;
`ifdef UART_CKSUM_EN
              cksum_d   = 8'd0;
`endif
            end
          end else if (rx_byte != HDR0) begin
            // A repeated HDR0 keeps us here so "AA AA 55" still syncs.
            state_d = S_HDR0;
          end
        end else if (tout_hit) begin
          err_d   = 1'b1;
          state_d = S_HDR0;
        end
      end
      S_PIX: begin
        if (byte_vld) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = rx_byte;
`ifdef UART_CKSUM_EN
          cksum_d   = cksum_q + rx_byte;
`endif
          if (cnt_q == LAST_PIX) begin
`ifdef UART_CKSUM_EN
            state_d   = S_CKSUM;
`else
            done_d    = 1'b1;
            loading_d = 1'b0;
            state_d   = S_HDR0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tout_hit) begin
          err_d     = 1'b1;
          loading_d = 1'b0;
          state_d   = S_HDR0;
        end
      end
`ifdef UART_CKSUM_EN
      S_CKSUM: begin
        if (byte_vld) begin
          done_d    = (rx_byte == cksum_q);
          err_d     = (rx_byte != cksum_q);
          loading_d = 1'b0;
          state_d   = S_HDR0;
        end else if (tout_hit) begin
          err_d     = 1'b1;
          loading_d = 1'b0;
          state_d   = S_HDR0;
        end
      end
`endif
      default: state_d = S_HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_HDR0;
      cnt_q     <= '0;
      tout_q    <= 24'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
      loading_q <= 1'b0;
`ifdef UART_CKSUM_EN
      cksum_q   <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tout_q    <= tout_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
      loading_q <= loading_d;
`ifdef UART_CKSUM_EN
      cksum_q   <= cksum_d;
`endif
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign frame_drop = drop_q;
  assign loading    = loading_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_loader
//  Description : Self-checking bench for uart_frame_loader. Expected pixel
//                writes are queued as bytes are sent; a monitor collects the
//                writes and pulses the DUT produces for the tests to compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_loader;

  localparam int          IMG_W   = 28;
  localparam int          IMG_H   = 28;
  localparam int          NPIX    = IMG_W * IMG_H;
  localparam int          ADDR_W  = 10;
  localparam logic [23:0] TOUT    = 24'd200;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_done = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              img_busy = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_done, frame_err, frame_drop, loading;

  uart_frame_loader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
    .HDR0(8'hAA), .HDR1(8'h55), .TIMEOUT_CLK(TOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .img_busy(img_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_err(frame_err), .frame_drop(frame_drop),
    .loading(loading)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [17:0] exp_q[$];
  logic [17:0] act_q[$];
  int done_cnt = 0, err_cnt = 0, drop_cnt = 0, excl_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (wr_en) act_q.push_back({wr_addr, wr_data});
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
    if (frame_drop) drop_cnt++;
    if ((int'(frame_done) + int'(frame_err) + int'(frame_drop)) > 1) excl_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic check_writes(input string name);
    logic [17:0] e, a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s missing write: got none, expected addr=%0d data=%02h", name, e[17:8], e[7:0]);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                   name, a[17:8], a[7:0], e[17:8], e[7:0]);
        end
      end
    end
    n_assert++;
    if (act_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s extra writes: got %0d, expected 0", name, act_q.size());
      act_q.delete();
    end
  endtask

  // Header, full frame (plus checksum when enabled), with latency checks.
  task automatic load_frame(input string name, input int hold, input bit bad_ck);
    int d0, e0;
    logic [7:0] ck, last;
    d0 = done_cnt;
    e0 = err_cnt;
    ck = 8'd0;
    send_byte(8'hAA, hold);
    send_byte(8'h55, hold);
    n_assert++;
    if (loading !== 1'b1) begin
      n_fail++;
      $display("FAIL %s loading after header: got %b, expected 1", name, loading);
    end
    for (int i = 0; i < NPIX; i++) begin
      last = 8'(i);
      exp_q.push_back({10'(i), last});
      ck = ck + last;
`ifndef UART_CKSUM_EN
      if (i == NPIX - 1) begin
        @(negedge clk);
        rx_data = last;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        n_assert++;
        if (frame_done !== 1'b1) begin
          n_fail++;
          $display("FAIL %s done latency: got %b, expected 1", name, frame_done);
        end
        repeat (hold) @(negedge clk);
        rx_done = 1'b0;
      end else
`endif
        send_byte(last, hold);
      if (i == NPIX / 2) begin
        n_assert++;
        if (loading !== 1'b1) begin
          n_fail++;
          $display("FAIL %s loading mid-frame: got %b, expected 1", name, loading);
        end
      end
    end
`ifdef UART_CKSUM_EN
    @(negedge clk);
    rx_data = bad_ck ? ck + 8'd1 : ck;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    n_assert++;
    if (frame_done !== !bad_ck || frame_err !== bad_ck) begin
      n_fail++;
      $display("FAIL %s cksum result: got done=%b err=%b, expected done=%b err=%b",
               name, frame_done, frame_err, !bad_ck, bad_ck);
    end
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_assert++;
    if (loading !== 1'b0) begin
      n_fail++;
      $display("FAIL %s loading after frame: got %b, expected 0", name, loading);
    end
    check_writes(name);
    n_assert++;
    if (done_cnt - d0 !== (bad_ck ? 0 : 1) || err_cnt - e0 !== (bad_ck ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s pulse counts: got done=%0d err=%0d, expected done=%0d err=%0d",
               name, done_cnt - d0, err_cnt - e0, bad_ck ? 0 : 1, bad_ck ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({wr_en, frame_done, frame_err, frame_drop, loading} !== 5'b0 || wr_addr !== '0 || wr_data !== 8'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got en=%b done=%b err=%b drop=%b load=%b addr=%0d data=%02h, expected all 0",
               wr_en, frame_done, frame_err, frame_drop, loading, wr_addr, wr_data);
    end
    n_assert++;
    if (dut.state_q !== 2'd0) begin
      n_fail++;
      $display("FAIL reset state: got %0d, expected 0", dut.state_q);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_frame();
    load_frame("full_frame", 1, 1'b0);
  endtask

  task automatic test_resync();
    send_byte(8'h12, 1);
    send_byte(8'hAA, 1);
    load_frame("resync", 1, 1'b0);
  endtask

  task automatic test_busy();
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    img_busy = 1'b1;
    send_byte(8'hAA, 1);
    @(negedge clk);
    rx_data = 8'h55;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    n_assert++;
    if (frame_drop !== 1'b1 || loading !== 1'b0) begin
      n_fail++;
      $display("FAIL busy drop pulse: got drop=%b load=%b, expected drop=1 load=0", frame_drop, loading);
    end
    @(negedge clk);
    rx_done = 1'b0;
    img_busy = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1);
    repeat (3) @(negedge clk);
    n_assert++;
    if (act_q.size() != 0 || done_cnt != d0 || err_cnt != e0) begin
      n_fail++;
      $display("FAIL busy ignored: got writes=%0d done=%0d err=%0d, expected 0 0 0",
               act_q.size(), done_cnt - d0, err_cnt - e0);
    end
    act_q.delete();
  endtask

  task automatic test_timeout();
    int e0, d0;
    e0 = err_cnt;
    d0 = done_cnt;
    send_byte(8'hAA, 1);
    send_byte(8'h55, 1);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({10'(i), 8'(i + 8'h30)});
      send_byte(8'(i + 8'h30), 1);
    end
    repeat (int'(TOUT) - 5) @(negedge clk);
    n_assert++;
    if (err_cnt != e0 || loading !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout early: got err=%0d load=%b, expected err=0 load=1", err_cnt - e0, loading);
    end
    repeat (10) @(negedge clk);
    n_assert++;
    if (err_cnt - e0 != 1 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL timeout pulse: got err=%0d done=%0d, expected err=1 done=0", err_cnt - e0, done_cnt - d0);
    end
    n_assert++;
    if (loading !== 1'b0 || dut.state_q !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout state: got load=%b state=%0d, expected load=0 state=0", loading, dut.state_q);
    end
    check_writes("timeout");
  endtask

  task automatic test_cksum_err();
`ifdef UART_CKSUM_EN
    load_frame("cksum_err", 1, 1'b1);
`endif
  endtask

  task automatic test_hold3();
    load_frame("hold3", 3, 1'b0);
  endtask

  task automatic test_reset_mid();
    int d0, e0, p0;
    send_byte(8'hAA, 1);
    send_byte(8'h55, 1);
    for (int i = 0; i < 400; i++) begin
      exp_q.push_back({10'(i), 8'(i ^ 8'h5A)});
      send_byte(8'(i ^ 8'h5A), 1);
    end
    check_writes("pre_reset");
    d0 = done_cnt;
    e0 = err_cnt;
    p0 = drop_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_assert++;
    if (loading !== 1'b0 || wr_en !== 1'b0 || dut.state_q !== 2'd0) begin
      n_fail++;
      $display("FAIL async reset: got load=%b en=%b state=%0d, expected 0 0 0", loading, wr_en, dut.state_q);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_assert++;
    if (done_cnt != d0 || err_cnt != e0 || drop_cnt != p0 || act_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset stray: got done=%0d err=%0d drop=%0d writes=%0d, expected all 0",
               done_cnt - d0, err_cnt - e0, drop_cnt - p0, act_q.size());
    end
    load_frame("after_reset", 1, 1'b0);
  endtask

  task automatic test_exclusive();
    n_assert++;
    if (excl_cnt != 0) begin
      n_fail++;
      $display("FAIL exclusive pulses: got %0d overlapping cycles, expected 0", excl_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_resync();
    test_busy();
    test_timeout();
    test_cksum_err();
    test_hold3();
    test_reset_mid();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
